// File: rtl/output_buffer_acc_pkg.sv
// Shared sizes, row/matrix vector types and lane/row slicing helpers for the
// systolic-array output buffer.
package output_buffer_acc_pkg;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int CNT_W = $clog2(N * N + 1);
  localparam int PTR_W = $clog2(N);

  typedef logic [N*DW-1:0]   row_t;
  typedef logic [N*N*DW-1:0] mat_t;

  function automatic int lane_lo(input int j);
    return DW * j;
  endfunction

  // Element (r,j) of a flattened matrix lives at index r*N+j.
  function automatic row_t mat_row(input mat_t m, input int r);
    row_t row;
    row = '0;
    for (int j = 0; j < N; j++) begin
      row[lane_lo(j) +: DW] = m[(r*N+j)*DW +: DW];
    end
    return row;
  endfunction

endpackage

// File: rtl/output_buffer_acc_matrix_reg.sv
// NxN register array of DW-bit elements supporting a single-row add, a
// full-matrix add and a clear; contents are exposed as one flat vector.
module obuf_matrix_reg
  import output_buffer_acc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             row_add_en,
  input  logic [PTR_W-1:0] row_idx,
  input  row_t             row_data,
  input  logic             mat_add_en,
  input  mat_t             mat_data,
  output mat_t             mat_q
);

  logic [DW-1:0] mem [N][N];

  // Both add sources may contribute in one cycle; sums wrap modulo 2^DW.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++)
          mem[r][j] <= '0;
    end else begin
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++)
          mem[r][j] <= mem[r][j]
                     + (mat_add_en ? mat_data[(r*N+j)*DW +: DW] : '0)
                     + ((row_add_en && row_idx == PTR_W'(r)) ? row_data[lane_lo(j) +: DW] : '0);
    end
  end

  always_comb begin
    mat_q = '0;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        mat_q[(r*N+j)*DW +: DW] = mem[r][j];
  end

endmodule

// File: rtl/output_buffer_acc.sv
// Output buffer: assembles a 16-beat tile into the load matrix, folds it into
// the accumulator on command and streams accumulator rows out in order.
module output_buffer_acc
  import output_buffer_acc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_en,
  input  logic load_clear,
  input  logic acc_enable,
  input  logic acc_clear,
  input  logic out_en,
  input  row_t in_res,
  output row_t out_res
);

  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] load_row;
  logic             load_fire;
  mat_t             load_mat;
  mat_t             acc_mat;

  assign load_row  = PTR_W'(cnt % CNT_W'(N));
  assign load_fire = load_en && !load_clear && (cnt < CNT_W'(N * N));

  obuf_matrix_reg u_load (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_clear),
    .row_add_en (load_fire),
    .row_idx    (load_row),
    .row_data   (in_res),
    .mat_add_en (1'b0),
    .mat_data   ('0),
    .mat_q      (load_mat)
  );

  // Accumulator adds the pre-edge load matrix, so a commit can share a cycle
  // with load_clear.
  obuf_matrix_reg u_acc (
    .clk        (clk),
    .rst        (rst),
    .clear      (acc_clear),
    .row_add_en (1'b0),
    .row_idx    ('0),
    .row_data   ('0),
    .mat_add_en (acc_enable),
    .mat_data   (load_mat),
    .mat_q      (acc_mat)
  );

  // Beat counter saturates at N*N so extra beats are dropped.
  always_ff @(posedge clk) begin
    if (!rst || load_clear) cnt <= '0;
    else if (load_fire)     cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr     <= '0;
      out_res <= '0;
    end else begin
      if (out_en) out_res <= mat_row(acc_mat, int'(ptr));
      if (acc_clear)   ptr <= '0;
      else if (out_en) ptr <= (ptr == PTR_W'(N - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_output_buffer_acc.sv
// Randomised and directed bench for output_buffer_acc with a queue-based
// scoreboard fed by a behavioural matrix model.
module tb_output_buffer_acc;
  import output_buffer_acc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_en = 1'b0, load_clear = 1'b0, acc_enable = 1'b0, acc_clear = 1'b0, out_en = 1'b0;
  row_t in_res = '0;
  row_t out_res;

  always #5 clk = ~clk;

  output_buffer_acc dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_clear (load_clear),
    .acc_enable (acc_enable),
    .acc_clear  (acc_clear),
    .out_en     (out_en),
    .in_res     (in_res),
    .out_res    (out_res)
  );

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] m_ld [N][N];
  logic [DW-1:0] m_ac [N][N];
  int   m_cnt;
  int   m_ptr;
  row_t exp_q [$];
  logic exp_valid = 1'b0;

  task automatic checkOutput(input string name, input row_t act, input row_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic modelReset();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        m_ld[r][j] = '0;
        m_ac[r][j] = '0;
      end
    m_cnt = 0;
    m_ptr = 0;
  endtask

  // One clock cycle of stimulus; the model advances with the same inputs.
  task automatic applyStimulus(input logic le, input logic lc, input logic ae,
                               input logic ac, input logic oe, input row_t d);
    row_t er;
    @(negedge clk);
    #1;
    load_en = le; load_clear = lc; acc_enable = ae; acc_clear = ac; out_en = oe; in_res = d;
    if (oe) begin
      er = '0;
      for (int j = 0; j < N; j++) er[DW*j +: DW] = m_ac[m_ptr][j];
      exp_q.push_back(er);
    end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        if (ac)      m_ac[r][j] = '0;
        else if (ae) m_ac[r][j] = m_ac[r][j] + m_ld[r][j];
      end
    if (lc) begin
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++) m_ld[r][j] = '0;
      m_cnt = 0;
    end else if (le && m_cnt < N*N) begin
      for (int j = 0; j < N; j++) m_ld[m_cnt % N][j] = m_ld[m_cnt % N][j] + d[DW*j +: DW];
      m_cnt++;
    end
    if (ac)      m_ptr = 0;
    else if (oe) m_ptr = (m_ptr + 1) % N;
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    load_en = 0; load_clear = 0; acc_enable = 0; acc_clear = 0; out_en = 0; in_res = '0;
    modelReset();
    exp_q.delete();
    @(negedge clk);
    #1;
    rst = 1'b1;
    checkOutput("reset_out", out_res, '0);
  endtask

  function automatic row_t fill(input logic [DW-1:0] v);
    row_t d;
    for (int j = 0; j < N; j++) d[DW*j +: DW] = v;
    return d;
  endfunction

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, '0);
  endtask

  task automatic readRows();
    for (int i = 0; i < N; i++) applyStimulus(0, 0, 0, 0, 1, '0);
  endtask

  task automatic commit();
    applyStimulus(0, 1, 1, 0, 0, '0);
  endtask

  // Lane j carries 1..4 on beats 4j..4j+3, so row r ends up as r+1 everywhere.
  task automatic loadTile(input int beats);
    row_t d;
    for (int b = 0; b < beats; b++) begin
      d = '0;
      d[DW*(b/N) +: DW] = DW'(b % N + 1);
      applyStimulus(1, 0, 0, 0, 0, d);
    end
  endtask

  always @(posedge clk) exp_valid <= out_en && rst;

  always @(negedge clk) begin
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL row: got %h expected none queued", out_res);
      end else begin
        checkOutput("row", out_res, exp_q.pop_front());
      end
    end
  end

  initial begin
    row_t d;
    modelReset();
    doReset();

    $display("[TB] idle after reset");
    idle();
    checkOutput("idle_out", out_res, '0);
    readRows();

    $display("[TB] single tile with extra beat");
    loadTile(N*N);
    d = '0; d[DW*3 +: DW] = 4;
    applyStimulus(1, 0, 0, 0, 0, d);
    commit();
    readRows();

    $display("[TB] multi-pass accumulation");
    applyStimulus(0, 0, 0, 1, 0, '0);
    for (int p = 0; p < 3; p++) begin loadTile(N*N); commit(); end
    readRows();
    for (int p = 0; p < 3; p++) begin loadTile(N*N); commit(); end
    readRows();

    $display("[TB] accumulator clear");
    applyStimulus(0, 0, 0, 1, 0, '0);
    readRows();
    loadTile(N*N);
    applyStimulus(0, 1, 1, 1, 0, '0);
    readRows();

    $display("[TB] load clear then commit");
    loadTile(N*N);
    applyStimulus(0, 1, 0, 0, 0, '0);
    applyStimulus(0, 0, 1, 0, 0, '0);
    readRows();
    applyStimulus(1, 0, 0, 0, 0, fill(7));
    commit();
    readRows();

    $display("[TB] wraparound");
    applyStimulus(0, 0, 0, 1, 0, '0);
    for (int b = 0; b < N; b++) applyStimulus(1, 0, 0, 0, 0, fill('1));
    commit();
    for (int b = 0; b < N; b++) applyStimulus(1, 0, 0, 0, 0, fill(2));
    commit();
    readRows();

    $display("[TB] reset mid-load");
    loadTile(5);
    doReset();
    readRows();
    applyStimulus(0, 0, 1, 0, 0, '0);
    readRows();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < N; j++) d[DW*j +: DW] = $urandom;
      applyStimulus(1'($urandom % 2), 1'($urandom % 16 == 0), 1'($urandom % 4 == 0),
                    1'($urandom % 16 == 0), 1'($urandom % 2), d);
    end
    idle();
    idle();

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("[TB] FAIL drain: got %0d rows pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/output_buffer_acc.md
Name: output_buffer_acc

Overview:
- Result collector behind the 4x4 systolic array.
- Gathers a 16-beat stream of N-lane partial results into an NxN load matrix.
- On command, adds the load matrix element-wise into an NxN accumulator matrix, for multi-pass (K-tiled) accumulation.
- Streams the accumulator out one row per cycle.

Parameters:
N, 4, array dimension (lanes per beat, rows/columns of both matrices)
DW, 32, element width in bits

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-low reset
load_en  in  1  capture in_res into the load matrix this cycle
load_clear  in  1  zero the load matrix and the beat counter
acc_enable  in  1  acc += load matrix (element-wise)
acc_clear  in  1  zero the accumulator matrix and the read pointer
out_en  in  1  emit one accumulator row per cycle
in_res  in  N*DW  lane j = in_res[DW*j+DW-1 : DW*j]
out_res  out  N*DW  registered accumulator row; lane j in same bit slice

Behaviour:
- Storage: load[r][j] and acc[r][j], for r,j in 0..N-1, each DW bits.
- State: beat counter cnt, 0..N*N, saturating. Read pointer ptr, 0..N-1.
- Reset (rst==0 at a clk edge): all load, acc, cnt, ptr and out_res go to 0. Reset overrides every other input.
- Load:
  - When load_en=1, load_clear=0 and cnt<N*N: row r=cnt mod N is updated per lane, load[r][j] <= load[r][j] + lane j of in_res; then cnt <= cnt+1.
  - When cnt==N*N, further load_en beats are ignored; load matrix and cnt are unchanged.
  - With zero-padded single-lane beats this assembles element (r,j) from beat j*N+r.
- load_clear=1: load <= 0 and cnt <= 0 next cycle. It wins over a simultaneous load_en, whose beat is dropped.
- Accumulate:
  - acc_enable=1 and acc_clear=0: acc[r][j] <= acc[r][j] + load[r][j] for all r,j in one cycle.
  - Uses the pre-edge load values, so acc_enable together with load_clear commits the current tile, then clears it.
  - Addition is DW-bit modulo; overflow wraps silently.
- acc_clear=1: acc <= 0 and ptr <= 0. It wins over acc_enable.
- Output:
  - out_en=1: out_res <= acc[ptr] (pre-edge acc), ptr <= (ptr+1) mod N. Latency is one cycle from out_en to valid row.
  - Rows emerge 0,1,..,N-1 over N consecutive out_en cycles and wrap thereafter.
  - out_en=0: out_res holds its last value and ptr holds.
- Simultaneous events:
  - out_en with acc_enable or acc_clear reads the old acc.
  - Reading never clears acc; the accumulator persists until acc_clear.
- Reset mid-operation behaves exactly as power-up reset.
- No handshake or back-pressure; the controller sequences all enables.

Decomposition:
- Shared package: N, DW, lane slice helper (lane index to bit range), typedef row_t = N x DW vector.
- One natural sub-module, obuf_matrix_reg: an NxN DW-bit register array with row-indexed add, full-matrix add, clear and row read. It is instantiated for load and for acc.
- Counter/pointer logic stays in the top level.

Test Plan:
1. rst=0 for one cycle, then idle -> out_res=0. Pulse out_en for 4 cycles -> four zero rows.
2. Load: load_en for 16 beats (lane j gets values 1,2,3,4 on beats 4j..4j+3, other lanes 0), plus one extra beat repeating value 4 on lane 3. Then acc_enable+load_clear together, then out_en for 4 cycles -> rows {1,1,1,1},{2,2,2,2},{3,3,3,3},{4,4,4,4}. The extra 17th beat must be ignored.
3. Run the same tile 3 times, each followed by acc_enable+load_clear, then out_en x4 -> rows of 3,6,9,12 in every lane. Repeat without acc_clear -> 6,12,18,24.
4. Assert acc_clear, then out_en x4 -> all zeros. acc_clear with acc_enable in the same cycle -> acc=0.
5. Load one tile; pulse load_clear alone; then acc_enable -> acc unchanged. Next 16-beat load restarts at row 0.
6. Preload acc lane value 0xFFFFFFFF, accumulate load value 2 -> 0x00000001 (wrap). Assert rst mid-load -> all state and out_res 0.
